// File: rtl/pov_spi_loader.sv
// SPI slave that receives a six-vector point-of-view frame, stages it, and
// applies it to the live registers only on the frame-boundary load strobe.
module pov_spi_loader #(
  parameter int QM          = 12,
  parameter int QN          = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_sclk,
  input  logic             spi_mosi,
  input  logic             spi_csb,
  input  logic             load_strobe,
  output logic [QM+QN-1:0] playerX,
  output logic [QM+QN-1:0] playerY,
  output logic [QM+QN-1:0] facingX,
  output logic [QM+QN-1:0] facingY,
  output logic [QM+QN-1:0] vplaneX,
  output logic [QM+QN-1:0] vplaneY,
  output logic             pending,
  output logic             frame_error
);

  localparam int W          = QM + QN;
  localparam int FRAME_BITS = 6 * W;
  localparam int CW         = $clog2(FRAME_BITS + 1);

  localparam logic [W-1:0] FX_ONE  = W'(1) << QN;
  localparam logic [W-1:0] FX_HALF = FX_ONE >> 1;
  localparam logic [W-1:0] FX_1P5  = FX_ONE + FX_HALF;
  localparam logic [W-1:0] FX_NEG1 = ~FX_ONE + W'(1);
  localparam logic [FRAME_BITS-1:0] RESET_FRAME =
    {FX_1P5, FX_1P5, W'(0), FX_NEG1, FX_HALF, W'(0)};

  // state  | meaning
  // IDLE   | csb high (or not yet armed); counter and shift held at 0
  // RECV   | shifting mosi on each sclk rise
  // OVER   | more than FRAME_BITS clocks seen; wait for csb rise
  // COMMIT | one clk: shift register -> staging, pending set
  typedef enum logic [1:0] {IDLE, RECV, OVER, COMMIT} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] csb_sync, sclk_sync, mosi_sync;
  logic                   csb_d, sclk_d;
  logic [SYNC_STAGES:0]   sync_valid;
  logic                   armed;
  logic                   csb_s, sclk_s, mosi_s;
  logic                   csb_fall, csb_rise, sclk_rise;

  logic [CW-1:0]         cnt;
  logic                  cnt_full;
  logic [FRAME_BITS-1:0] shift_reg, staging, live;
  logic                  do_clear, do_shift, do_error, do_commit;

  assign csb_s  = csb_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // A csb already low at reset release must not look like a new frame start.
  assign csb_fall  = armed & csb_d & ~csb_s;
  assign csb_rise  = ~csb_d & csb_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign cnt_full  = (cnt == CW'(FRAME_BITS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csb_sync   <= '1;
      sclk_sync  <= '0;
      mosi_sync  <= '0;
      csb_d      <= 1'b1;
      sclk_d     <= 1'b0;
      sync_valid <= '0;
      armed      <= 1'b0;
    end else begin
      csb_sync   <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      csb_d      <= csb_s;
      sclk_d     <= sclk_s;
      sync_valid <= {sync_valid[SYNC_STAGES-1:0], 1'b1};
      armed      <= armed | (&sync_valid & csb_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_clear   = 1'b0;
    do_shift   = 1'b0;
    do_error   = 1'b0;
    do_commit  = 1'b0;
    case (state)
      IDLE: begin
        do_clear = 1'b1;
        if (csb_fall) state_next = RECV;
      end
      RECV: begin
        if (csb_rise) begin
          if (cnt_full) begin
            state_next = COMMIT;
          end else begin
            state_next = IDLE;
            do_clear   = 1'b1;
            do_error   = 1'b1;
          end
        end else if (sclk_rise) begin
          if (cnt_full) begin
            state_next = OVER;
            do_error   = 1'b1;
          end else begin
            do_shift = 1'b1;
          end
        end
      end
      OVER: begin
        if (csb_rise) begin
          state_next = IDLE;
          do_clear   = 1'b1;
        end
      end
      COMMIT: begin
        do_commit  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      shift_reg   <= '0;
      frame_error <= 1'b0;
    end else begin
      if (do_clear) begin
        cnt       <= '0;
        shift_reg <= '0;
      end else if (do_shift) begin
        cnt       <= cnt + CW'(1);
        shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_s};
      end
      if (do_error) frame_error <= 1'b1;
    end
  end

  // Live takes the old staging before a coincident commit replaces it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging <= RESET_FRAME;
      live    <= RESET_FRAME;
      pending <= 1'b0;
    end else begin
      if (load_strobe && pending) live <= staging;
      if (do_commit) begin
        staging <= shift_reg;
        pending <= 1'b1;
      end else if (load_strobe && pending) begin
        pending <= 1'b0;
      end
    end
  end

  assign playerX = live[6*W-1 -: W];
  assign playerY = live[5*W-1 -: W];
  assign facingX = live[4*W-1 -: W];
  assign facingY = live[3*W-1 -: W];
  assign vplaneX = live[2*W-1 -: W];
  assign vplaneY = live[W-1 -: W];

endmodule

// File: doc/pov_spi_loader.md
Name: pov_spi_loader

Overview:
- SPI slave that receives a complete point-of-view update: playerX, playerY, facingX, facingY, vplaneX and vplaneY, as signed fixed-point QM.QN values.
- A completed frame is held in a staging buffer. It is applied to the live registers only on a frame-boundary strobe, so the tracer and the debug display never see a half-updated view within a frame.
- It is the write side of the POV vectors that the renderer and the debug display consume.

Parameters:
- QM, 12, integer bits of each fixed-point vector (includes sign).
- QN, 12, fractional bits of each fixed-point vector.
- SYNC_STAGES, 2, flip-flop stages on each SPI input synchroniser (minimum 2).

Ports:
- clk  input  1  system/pixel clock.
- reset  input  1  asynchronous, active-high reset.
- spi_sclk  input  1  SPI clock, asynchronous to clk; mode 0.
- spi_mosi  input  1  SPI data in, MSB first.
- spi_csb  input  1  SPI chip select, active-low, asynchronous.
- load_strobe  input  1  one-clk pulse at the frame boundary (end of visible frame).
- playerX, playerY, facingX, facingY, vplaneX, vplaneY  output  QM+QN each  live POV registers.
- pending  output  1  a complete, valid frame is staged and waiting for load_strobe.
- frame_error  output  1  sticky; set by any aborted or over-length SPI frame; cleared only by reset.

Behaviour:
- Reset values (asynchronous): all synchroniser flops are 1 for csb and 0 for sclk/mosi; the bit counter and the shift register are 0; pending=0; frame_error=0.
- Live vector reset values:
  - playerX = playerY = 1.5
  - facingX = 0.0, facingY = -1.0
  - vplaneX = 0.5, vplaneY = 0.0
  - All in two's-complement QM.QN.
- Staging buffer resets to the same values as the live vectors.
- Input sync: each SPI input passes through SYNC_STAGES flops. The edge detector uses the last synced stage against one further delayed copy.
- Transaction length is FRAME_BITS = 6*(QM+QN), i.e. 144 bits at the defaults.
- Field order on the wire: playerX, playerY, facingX, facingY, vplaneX, vplaneY, each sent MSB first.
- States:
  - IDLE: synced csb high. The counter is held at 0.
    - csb falling → RECV, counter=0.
  - RECV: on each synced sclk rising edge, shift in synced mosi (shift left, LSB entry) and increment the counter.
    - Once the counter reaches FRAME_BITS, further sclk edges do not shift and do not increment; the state becomes OVER.
    - csb rising with counter==FRAME_BITS → COMMIT.
    - csb rising with counter!=FRAME_BITS → discard the shift data, set frame_error, go to IDLE.
  - OVER: entered on the first sclk rising edge after the counter has reached FRAME_BITS. Sets frame_error.
    - csb rising → IDLE with no commit.
  - COMMIT (exactly one clk): copy the shift register to staging, set pending=1, go to IDLE.
- Latency: staging is updated, and pending rises, 1 clk after the synced csb rise is detected. The synced csb rise itself arrives SYNC_STAGES+1 clk after the pin edge.
- On load_strobe with pending=1: live vectors ← staging and pending ← 0, effective on the next clk. On load_strobe with pending=0: no change.
- Simultaneous COMMIT and load_strobe in the same clk:
  - Live registers take the old staging contents only if pending was already 1.
  - Staging takes the new frame.
  - pending ends the cycle at 1.
- A second complete frame before load_strobe overwrites staging. pending stays 1 and no error is flagged.
- A csb glitch shorter than the synchroniser may be missed. That is legal; no requirement applies.
- The SPI master must keep sclk at or below clk/4; faster rates are not supported.
- Reset asserted mid-transaction: everything returns to reset values immediately. A transfer still in flight when reset releases is ignored until the next csb high→low transition.

Test Plan:
- Reset value check: assert reset, release, run 10 clk with no SPI activity. With QN=12 the live values must read: playerX=playerY=0x001800, facingX=0x000000, facingY=0xFFF000, vplaneX=0x000800, vplaneY=0x000000. pending=0, frame_error=0.
- Good frame, then load:
  - Send 144 bits with playerX=0x003000, playerY=0x004800, facingX=0x001000, facingY=0, vplaneX=0, vplaneY=0x000800, at sclk=clk/8.
  - Required: pending=1 and the live vectors unchanged.
  - Pulse load_strobe. Required: the live vectors equal the sent values next clk and pending=0.
- Short frame: csb rises after 100 bits → frame_error=1, pending=0, staging and live unchanged.
- Long frame: send 150 bits → frame_error=1, pending=0, no commit.
- Coincident commit and strobe: stage frame A and leave pending=1. Send frame B timed so that COMMIT and load_strobe land in the same clk. Required: live=A, staging=B, pending=1. A second strobe then gives live=B and pending=0.
- Reset mid-transfer: assert reset after 60 bits, release, then send a good frame. It commits correctly, and live holds reset values until load_strobe.
